// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, cin,
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, one bit per
// clock, LSB first. Result, carry-out and signed overflow are held until the
// next completion.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             busy_d;
  logic             done_d;
  logic             last_step;

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;
  logic fa_s;
  logic fa_co;

  // Full-adder cell: two half-adders and a carry OR on the current LSB pair.
  always_comb begin
    ha1_s = a_sh[0] ^ b_sh[0];
    ha1_c = a_sh[0] & b_sh[0];
    fa_s  = ha1_s ^ c_q;
    ha2_c = ha1_s & c_q;
    fa_co = ha1_c | ha2_c;
  end

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and next-value of the busy/done flags.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) state_d = ADD;
      ADD:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.busy <= busy_d;
      bus.done <= done_d;
    end
  end

  // Operand capture, serial shift/add, and result capture on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      c_q      <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            c_q   <= bus.cin;
            cnt_q <= '0;
          end
        end
        ADD: begin
          c_q    <= fa_co;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step) begin
            // c_q here is the carry into the MSB
            bus.sum  <= {fa_s, sum_sh[WIDTH-1:1]};
            bus.cout <= fa_co;
            bus.ovf  <= c_q ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=4 instances,
// directed corner cases plus random operands against an arithmetic model.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Selected instance: 0 = WIDTH 8, 1 = WIDTH 4
  bit       sel = 1'b0;
  logic [7:0] o_sum;
  logic       o_cout;
  logic       o_ovf;
  logic       o_busy;
  logic       o_done;

  always_comb begin
    if (sel) begin
      o_sum  = {4'b0, if4.sum};
      o_cout = if4.cout;
      o_ovf  = if4.ovf;
      o_busy = if4.busy;
      o_done = if4.done;
    end else begin
      o_sum  = if8.sum;
      o_cout = if8.cout;
      o_ovf  = if8.ovf;
      o_busy = if8.busy;
      o_done = if8.done;
    end
  end

  // Last completed result per instance (outputs must hold these between ops)
  logic [7:0] held_sum  [2];
  logic       held_cout [2];
  logic       held_ovf  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit s, input logic st, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci);
    if (s) begin
      if4.start = st;
      if4.a     = av[3:0];
      if4.b     = bv[3:0];
      if4.cin   = ci;
    end else begin
      if8.start = st;
      if8.a     = av;
      if8.b     = bv;
      if8.cin   = ci;
    end
  endtask

  task automatic reset_held();
    for (int i = 0; i < 2; i++) begin
      held_sum[i]  = '0;
      held_cout[i] = 1'b0;
      held_ovf[i]  = 1'b0;
    end
  endtask

  // One operation, called at a negedge with the selected instance in IDLE;
  // returns at the negedge one cycle after done (instance back in IDLE).
  // hold=1 keeps start high with a=b=1 throughout the busy phase.
  task automatic op(input bit s, input logic [7:0] av_in, input logic [7:0] bv_in,
                    input logic ci, input bit hold);
    int unsigned w;
    logic [8:0]  full;
    logic [7:0]  mask;
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [7:0]  es;
    logic        ec;
    logic        eo;
    w    = s ? 4 : 8;
    mask = s ? 8'h0F : 8'hFF;
    av   = av_in & mask;
    bv   = bv_in & mask;
    full = 9'(av) + 9'(bv) + 9'(ci);
    es   = full[7:0] & mask;
    ec   = full[w];
    eo   = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);

    sel = s;
    drive(s, 1'b1, av, bv, ci);
    @(posedge clk);
    #1;
    if (hold) drive(s, 1'b1, 8'h01, 8'h01, 1'b0);
    else      drive(s, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    @(negedge clk);
    chk("busy_after_accept", 32'(o_busy), 32'd1);
    chk("done_low_early", 32'(o_done), 32'd0);
    chk("sum_held_during_op", 32'(o_sum), 32'(held_sum[s]));
    chk("cout_held_during_op", 32'(o_cout), 32'(held_cout[s]));
    repeat (w - 1) @(negedge clk);
    chk("done_low_before_last", 32'(o_done), 32'd0);
    chk("busy_before_last", 32'(o_busy), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("busy_low_at_done", 32'(o_busy), 32'd0);
    chk("sum", 32'(o_sum), 32'(es));
    chk("cout", 32'(o_cout), 32'(ec));
    chk("ovf", 32'(o_ovf), 32'(eo));
    held_sum[s]  = es;
    held_cout[s] = ec;
    held_ovf[s]  = eo;
    drive(s, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("idle_not_busy", 32'(o_busy), 32'd0);
    chk("sum_held_after", 32'(o_sum), 32'(es));
    chk("ovf_held_after", 32'(o_ovf), 32'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    reset_held();
    repeat (2) @(negedge clk);

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #0;
      chk("rst_sum", 32'(o_sum), 32'd0);
      chk("rst_cout", 32'(o_cout), 32'd0);
      chk("rst_ovf", 32'(o_ovf), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 cases
    op(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
    op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    op(1'b0, 8'hA5, 8'h5A, 1'b1, 1'b1);
    chk("ignored_start_sum", 32'(o_sum), 32'h00);

    // Reset three cycles after accept aborts the operation
    sel = 1'b0;
    drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_sum", 32'(o_sum), 32'd0);
    chk("abort_cout", 32'(o_cout), 32'd0);
    reset_held();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(o_done), 32'd0);
    end
    op(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    chk("fresh_after_rst_sum", 32'(o_sum), 32'h46);

    // Random WIDTH=8 operations
    for (int i = 0; i < 20; i++)
      op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    // WIDTH=4 instance, including back-to-back starts
    op(1'b1, 8'h0F, 8'h0F, 1'b1, 1'b0);
    op(1'b1, 8'h07, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
